// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, block width and the round-sequencer state encoding.
package aes_pkg;

  localparam int AES_NR  = 10;
  localparam int BLOCK_W = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: initial AddRoundKey, then issues rounds 1..NR to an
// external registered round datapath and returns the final state on a valid/ready port.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR,
  parameter int ROUND_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [BLOCK_W-1:0] rd_in_data,
  output logic [BLOCK_W-1:0] rd_in_key,
  output logic [3:0]         rd_round,
  output logic               rd_last,
  input  logic [BLOCK_W-1:0] rd_out_data,
  input  logic [BLOCK_W-1:0] rd_out_key
);

  localparam int                WCNT_W     = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(ROUND_LAT - 1);
  localparam logic [3:0]        ROUND_LAST = 4'(NR);

  seq_state_e        state_q;
  block_t            data_q;
  block_t            key_q;
  logic [WCNT_W-1:0] wcnt_q;

  // The datapath sees the working state and previous round key directly from the registers.
  assign rd_in_data = data_q;
  assign rd_in_key  = key_q;

  // rd_round doubles as the round counter: it is nonzero exactly while a round is issued.
  always_ff @(posedge clk) begin
    // NOTE: every state element uses <= so all registers update from pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      rd_round  <= '0;
      rd_last   <= 1'b0;
      data_q    <= '0;
      key_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            key_q    <= in_key;
            in_ready <= 1'b0;
            state_q  <= ST_INIT;
          end
        end

        ST_INIT: begin
          data_q   <= data_q ^ key_q;
          rd_round <= 4'd1;
          rd_last  <= (ROUND_LAST == 4'd1);
          wcnt_q   <= '0;
          state_q  <= ST_ROUND;
        end

        ST_ROUND: begin
          if (wcnt_q == WCNT_LAST) begin
            data_q <= rd_out_data;
            key_q  <= rd_out_key;
            wcnt_q <= '0;
            if (rd_round == ROUND_LAST) begin
              out_data  <= rd_out_data;
              out_valid <= 1'b1;
              rd_round  <= '0;
              rd_last   <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              rd_round <= rd_round + 4'd1;
              rd_last  <= ((rd_round + 4'd1) == ROUND_LAST);
            end
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: stub XOR/increment datapath, reference model built from
// the round rules, three parameterisations (NR/ROUND_LAT = 10/2, 14/1, 14/3).
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int NR0 = 10;
  localparam int L0  = 2;
  localparam int NRS = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         in_valid_v  [3];
  logic         out_ready_v [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         rd_last_w   [3];
  logic [3:0]   rd_round_w  [3];
  logic [127:0] out_data_w    [3];
  logic [127:0] rd_in_data_w  [3];
  logic [127:0] rd_in_key_w   [3];
  logic [127:0] rd_out_data_w [3];
  logic [127:0] rd_out_key_w  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GNR = (g == 0) ? NR0 : NRS;
    localparam int GL  = (g == 0) ? L0 : ((g == 1) ? 1 : 3);

    logic [127:0] nd, nk;
    logic [127:0] pd [0:GL-1];
    logic [127:0] pk [0:GL-1];

    assign nd = rd_in_data_w[g] ^ {124'b0, rd_round_w[g]};
    assign nk = rd_in_key_w[g] + 128'd1;

    // The sequencer samples on the GL-th edge after issue, so GL-1 register stages in front
    // of that sample edge give a result that is valid exactly on time and stale any earlier.
    always @(posedge clk) begin
      pd[0] <= nd;
      pk[0] <= nk;
      for (int i = 1; i < GL; i++) begin
        pd[i] <= pd[i-1];
        pk[i] <= pk[i-1];
      end
    end

    if (GL == 1) begin : g_comb
      assign rd_out_data_w[g] = nd;
      assign rd_out_key_w[g]  = nk;
    end else begin : g_reg
      assign rd_out_data_w[g] = pd[GL-2];
      assign rd_out_key_w[g]  = pk[GL-2];
    end

    aes_round_sequencer #(.NR(GNR), .ROUND_LAT(GL)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_v[g]),
      .in_ready   (in_ready_w[g]),
      .in_data    (in_data),
      .in_key     (in_key),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready_v[g]),
      .out_data   (out_data_w[g]),
      .rd_in_data (rd_in_data_w[g]),
      .rd_in_key  (rd_in_key_w[g]),
      .rd_round   (rd_round_w[g]),
      .rd_last    (rd_last_w[g]),
      .rd_out_data(rd_out_data_w[g]),
      .rd_out_key (rd_out_key_w[g])
    );
  end

  // State after the initial AddRoundKey and the first `rounds` stub rounds.
  function automatic logic [127:0] model_state(input logic [127:0] d, input logic [127:0] k,
                                               input int rounds);
    logic [127:0] s;
    s = d ^ k;
    for (int r = 1; r <= rounds; r++) s = s ^ 128'(r);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One block through instance 0, with `bp` cycles of output backpressure.
  task automatic run_block(input logic [127:0] d, input logic [127:0] k, input int bp);
    logic [127:0] exp_out;
    int m;
    int r;
    int guard;
    exp_out = model_state(d, k, NR0);
    guard = 0;
    while (!in_ready_w[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", 128'(in_ready_w[0]), 128'd1);
    in_data        = d;
    in_key         = k;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = (bp == 0);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    in_data       = ~d;
    in_key        = ~k;
    m = 0;
    while (!out_valid_w[0] && m < 200) begin
      check("busy_in_ready", 128'(in_ready_w[0]), 128'd0);
      if (m == 0) begin
        check("init_rd_round", 128'(rd_round_w[0]), 128'd0);
      end else begin
        r = (m - 1) / L0 + 1;
        check("rd_round", 128'(rd_round_w[0]), 128'(r));
        check("rd_last", 128'(rd_last_w[0]), 128'(r == NR0));
        check("rd_in_key", rd_in_key_w[0], k + 128'(r - 1));
        check("rd_in_data", rd_in_data_w[0], model_state(d, k, r - 1));
      end
      @(negedge clk);
      m++;
    end
    check("latency", 128'(m), 128'(1 + NR0 * L0));
    check("out_data", out_data_w[0], exp_out);
    check("done_rd_round", 128'(rd_round_w[0]), 128'd0);
    for (int i = 0; i < bp; i++) begin
      in_valid_v[0] = 1'b1;
      in_data       = rand128();
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid_w[0]), 128'd1);
      check("bp_out_data", out_data_w[0], exp_out);
      check("bp_in_ready", 128'(in_ready_w[0]), 128'd0);
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    check("post_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("post_in_ready", 128'(in_ready_w[0]), 128'd1);
    @(negedge clk);
    check("idle_rd_round", 128'(rd_round_w[0]), 128'd0);
    check("idle_in_ready", 128'(in_ready_w[0]), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] bd [2];
    logic [127:0] bk [2];
    int acc_t [2];
    int nacc;
    int nout;
    int guard;
    bit acc_now;
    int lat1;
    int lat2;
    logic [127:0] sd, sk;

    rst     = 1'b1;
    in_data = '0;
    in_key  = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
    end
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("rst_out_data", out_data_w[0], 128'd0);
    check("rst_rd_round", 128'(rd_round_w[0]), 128'd0);
    check("rst_rd_last", 128'(rd_last_w[0]), 128'd0);
    check("rst_rd_in_data", rd_in_data_w[0], 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero block, then FF/0F block, then backpressure.
    run_block(128'h0, 128'h0, 0);
    run_block(128'hFF, 128'h0F, 0);
    run_block(rand128(), rand128(), 5);
    for (int i = 0; i < 3; i++) run_block(rand128(), rand128(), i);

    // Reset while round 4 is issued.
    in_data       = rand128();
    in_key        = rand128();
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    guard = 0;
    while (rd_round_w[0] != 4'd4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_round4", 128'(rd_round_w[0]), 128'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 128'(in_ready_w[0]), 128'd1);
    check("abort_out_valid", 128'(out_valid_w[0]), 128'd0);
    check("abort_rd_round", 128'(rd_round_w[0]), 128'd0);
    check("abort_rd_last", 128'(rd_last_w[0]), 128'd0);
    run_block(128'h0, 128'h0, 0);

    // Back-to-back: in_valid held high across two blocks.
    for (int b = 0; b < 2; b++) begin
      bd[b] = rand128();
      bk[b] = rand128();
    end
    out_ready_v[0] = 1'b1;
    in_data        = bd[0];
    in_key         = bk[0];
    in_valid_v[0]  = 1'b1;
    nacc  = 0;
    nout  = 0;
    guard = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    while (nout < 2 && guard < 300) begin
      acc_now = in_valid_v[0] && in_ready_w[0];
      if (out_valid_w[0]) begin
        check("b2b_out_data", out_data_w[0], model_state(bd[nout], bk[nout], NR0));
        nout++;
      end
      @(negedge clk);
      guard++;
      if (acc_now && nacc < 2) begin
        acc_t[nacc] = guard;
        nacc++;
        if (nacc < 2) begin
          in_data = bd[1];
          in_key  = bk[1];
        end else begin
          in_valid_v[0] = 1'b0;
        end
      end
    end
    in_valid_v[0] = 1'b0;
    check("b2b_outputs", 128'(nout), 128'd2);
    check("b2b_accepts", 128'(nacc), 128'd2);
    check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(3 + NR0 * L0));

    // Parameter sweep: NR=14 with ROUND_LAT 1 and 3, started on the same edge.
    sd = rand128();
    sk = rand128();
    check("sweep1_ready", 128'(in_ready_w[1]), 128'd1);
    check("sweep2_ready", 128'(in_ready_w[2]), 128'd1);
    in_data       = sd;
    in_key        = sk;
    in_valid_v[1] = 1'b1;
    in_valid_v[2] = 1'b1;
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    in_valid_v[2] = 1'b0;
    in_data       = rand128();
    lat1 = -1;
    lat2 = -1;
    guard = 0;
    while ((lat1 < 0 || lat2 < 0) && guard < 200) begin
      if (out_valid_w[1] && lat1 < 0) begin
        lat1 = guard;
        check("sweep1_data", out_data_w[1], model_state(sd, sk, NRS));
      end
      if (out_valid_w[2] && lat2 < 0) begin
        lat2 = guard;
        check("sweep2_data", out_data_w[2], model_state(sd, sk, NRS));
      end
      @(negedge clk);
      guard++;
    end
    check("sweep1_latency", 128'(lat1), 128'(1 + NRS * 1));
    check("sweep2_latency", 128'(lat2), 128'(1 + NRS * 3));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
